// File: rtl/gs_multiplex_sequencer.sv
// Grayscale shift sequencer for the multiplexed LED driver chain.
// Walks color/LED/bit-plane/row counters on SCLK rising edges and drives row enables and latch strobes.
module gs_multiplex_sequencer #(
    parameter int unsigned NB_ANGLES         = 128,
    parameter int unsigned NB_LEDS_PER_GROUP = 16,
    parameter int unsigned NB_COLORS         = 3,
    parameter int unsigned NB_BITS           = 10,
    parameter int unsigned NB_ROWS           = 4,
    localparam int unsigned AW = $clog2(NB_ANGLES),
    localparam int unsigned CW = (NB_COLORS > 1) ? $clog2(NB_COLORS) : 1,
    localparam int unsigned LW = $clog2(NB_LEDS_PER_GROUP),
    localparam int unsigned BW = $clog2(NB_BITS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SCLK,
    input  logic [AW-1:0]      angle,
    input  logic               FC_en,
    output logic [CW-1:0]      color,
    output logic [LW-1:0]      led,
    output logic [BW-1:0]      bit_sel,
    output logic [NB_ROWS-1:0] row_en,
    output logic               LAT,
    output logic               LATGS,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned RW = (NB_ROWS > 1) ? $clog2(NB_ROWS) : 1;
    localparam logic [NB_ROWS-1:0] ROW_ONE = NB_ROWS'(1);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_DISPLAY = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_color;
    logic [LW-1:0]  r_led;
    logic [BW-1:0]  r_bit;
    logic [RW-1:0]  r_row;
    logic           r_prev_sclk;
    logic [AW-1:0]  r_prev_angle;
    logic           r_frame_done;

    logic w_sclk_edge;
    logic w_restart;
    logic w_end_color;
    logic w_end_led;
    logic w_end_bit;
    logic w_advance;
    logic w_end_phase;
    logic w_active;

    assign w_sclk_edge = SCLK & ~r_prev_sclk;
    assign w_restart   = FC_en | (angle != r_prev_angle);
    assign w_end_color = (r_color == CW'(NB_COLORS - 1));
    assign w_end_led   = (r_led == LW'(NB_LEDS_PER_GROUP - 1));
    assign w_end_bit   = (r_bit == '0);
    assign w_active    = (r_state != ST_FINISH);
    assign w_advance   = w_sclk_edge & ~w_restart & w_active;
    assign w_end_phase = w_advance & w_end_color & w_end_led & w_end_bit;

    // Restart beats a coincident SCLK edge; FINISH holds every counter until restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_color      <= '0;
            r_led        <= '0;
            r_bit        <= BW'(NB_BITS - 1);
            r_row        <= '0;
            r_prev_sclk  <= 1'b0;
            r_prev_angle <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_prev_sclk  <= SCLK;
            r_prev_angle <= angle;
            r_frame_done <= 1'b0;
            if (w_restart) begin
                r_state <= ST_INIT;
                r_color <= '0;
                r_led   <= '0;
                r_bit   <= BW'(NB_BITS - 1);
                r_row   <= '0;
            end else if (w_advance) begin
                r_color <= w_end_color ? '0 : r_color + CW'(1);
                if (w_end_color) begin
                    r_led <= w_end_led ? '0 : r_led + LW'(1);
                end
                if (w_end_color && w_end_led) begin
                    r_bit <= w_end_bit ? BW'(NB_BITS - 1) : r_bit - BW'(1);
                end
                if (w_end_phase) begin
                    case (r_state)
                        ST_INIT: begin
                            r_state <= ST_DISPLAY;
                            r_row   <= '0;
                        end
                        ST_DISPLAY: begin
                            if (r_row == RW'(NB_ROWS - 1)) begin
                                r_state      <= ST_FINISH;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_row <= r_row + RW'(1);
                            end
                        end
                        default: r_state <= r_state;
                    endcase
                end
            end
        end
    end

    // Output decode straight from registers.
    assign color      = r_color;
    assign led        = r_led;
    assign bit_sel    = r_bit;
    assign row_en     = (r_state == ST_DISPLAY) ? (ROW_ONE << r_row) : '0;
    assign LAT        = w_end_led & w_end_color & w_active;
    assign LATGS      = LAT & w_end_bit;
    assign busy       = w_active;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_gs_multiplex_sequencer.sv
// Directed bench for gs_multiplex_sequencer: default build plus a 4-color/8-bit/2-row build.
module tb_gs_multiplex_sequencer;

    logic       clk;
    logic       rst_n;
    logic       SCLK;
    logic       sclk2;
    logic [6:0] angle;
    logic       FC_en;

    logic [1:0] color;
    logic [3:0] led;
    logic [3:0] bit_sel;
    logic [3:0] row_en;
    logic       LAT, LATGS, busy, frame_done;

    logic [1:0] color2;
    logic [3:0] led2;
    logic [2:0] bit_sel2;
    logic [1:0] row_en2;
    logic       lat2, latgs2, busy2, frame_done2;

    int chk_cnt;
    int pass_cnt;
    int fd_cnt;

    gs_multiplex_sequencer dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .angle(angle), .FC_en(FC_en),
        .color(color), .led(led), .bit_sel(bit_sel), .row_en(row_en),
        .LAT(LAT), .LATGS(LATGS), .busy(busy), .frame_done(frame_done)
    );

    gs_multiplex_sequencer #(.NB_COLORS(4), .NB_BITS(8), .NB_ROWS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk2), .angle(angle), .FC_en(FC_en),
        .color(color2), .led(led2), .bit_sel(bit_sel2), .row_en(row_en2),
        .LAT(lat2), .LATGS(latgs2), .busy(busy2), .frame_done(frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;

    task automatic pulse(input int n);
        repeat (n) begin
            @(negedge clk) SCLK = 1'b1;
            @(negedge clk) SCLK = 1'b0;
        end
    endtask

    task automatic pulse2(input int n);
        repeat (n) begin
            @(negedge clk) sclk2 = 1'b1;
            @(negedge clk) sclk2 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SCLK = 1'b0; sclk2 = 1'b0; angle = '0; FC_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if ({color, led, bit_sel} !== {2'd0, 4'd0, 4'd9}) $display("FAIL reset_cnt got %h exp %h", {color, led, bit_sel}, {2'd0, 4'd0, 4'd9}); else pass_cnt++;
        chk_cnt++; if ({row_en, LAT, LATGS, busy, frame_done} !== 8'b0000_0010) $display("FAIL reset_out got %b exp %b", {row_en, LAT, LATGS, busy, frame_done}, 8'b0000_0010); else pass_cnt++;
        chk_cnt++; if ({color2, led2, bit_sel2, row_en2, busy2} !== {2'd0, 4'd0, 3'd7, 2'b00, 1'b1}) $display("FAIL reset_dut2 got %h exp %h", {color2, led2, bit_sel2, row_en2, busy2}, {2'd0, 4'd0, 3'd7, 2'b00, 1'b1}); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_plane();
        for (int i = 0; i < 48; i++) begin
            chk_cnt++; if (color !== 2'(i % 3) || led !== 4'(i / 3)) $display("FAIL slot%0d_color_led got %0d/%0d exp %0d/%0d", i, color, led, i % 3, i / 3); else pass_cnt++;
            chk_cnt++; if (LAT !== (i == 47) || LATGS !== 1'b0) $display("FAIL slot%0d_lat got %b%b exp %b0", i, LAT, LATGS, (i == 47)); else pass_cnt++;
            pulse(1);
        end
        chk_cnt++; if (bit_sel !== 4'd8 || LAT !== 1'b0) $display("FAIL plane1_bit got %0d lat %b exp 8 lat 0", bit_sel, LAT); else pass_cnt++;
    endtask

    task automatic test_row_phase();
        pulse(431);
        chk_cnt++; if ({LAT, LATGS, busy, bit_sel, row_en} !== {1'b1, 1'b1, 1'b1, 4'd0, 4'b0000}) $display("FAIL slot480 got %b exp %b", {LAT, LATGS, busy, bit_sel, row_en}, {3'b111, 4'd0, 4'b0000}); else pass_cnt++;
        pulse(1);
        chk_cnt++; if (row_en !== 4'b0001) $display("FAIL display_row0 got %b exp 0001", row_en); else pass_cnt++;
        chk_cnt++; if ({color, led, bit_sel, LATGS} !== {2'd0, 4'd0, 4'd9, 1'b0}) $display("FAIL display_cnt got %h exp %h", {color, led, bit_sel, LATGS}, {2'd0, 4'd0, 4'd9, 1'b0}); else pass_cnt++;
    endtask

    task automatic test_frame();
        fd_cnt = 0;
        pulse(480);
        chk_cnt++; if (row_en !== 4'b0010) $display("FAIL row1 got %b exp 0010", row_en); else pass_cnt++;
        pulse(480);
        chk_cnt++; if (row_en !== 4'b0100) $display("FAIL row2 got %b exp 0100", row_en); else pass_cnt++;
        pulse(480);
        chk_cnt++; if (row_en !== 4'b1000) $display("FAIL row3 got %b exp 1000", row_en); else pass_cnt++;
        pulse(479);
        chk_cnt++; if ({row_en, busy, LATGS, frame_done} !== 7'b1000_110) $display("FAIL edge2399 got %b exp 1000110", {row_en, busy, LATGS, frame_done}); else pass_cnt++;
        pulse(1);
        chk_cnt++; if ({row_en, busy, LAT, LATGS, frame_done} !== 8'b0000_0001) $display("FAIL finish got %b exp 00000001", {row_en, busy, LAT, LATGS, frame_done}); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (frame_done !== 1'b0) $display("FAIL done_pulse got %b exp 0", frame_done); else pass_cnt++;
        pulse(10);
        chk_cnt++; if ({color, led, bit_sel, row_en, busy, LAT} !== {2'd0, 4'd0, 4'd9, 4'b0000, 1'b0, 1'b0}) $display("FAIL frozen got %h exp %h", {color, led, bit_sel, row_en, busy, LAT}, {2'd0, 4'd0, 4'd9, 4'b0000, 2'b00}); else pass_cnt++;
        chk_cnt++; if (fd_cnt !== 1) $display("FAIL done_count got %0d exp 1", fd_cnt); else pass_cnt++;
    endtask

    task automatic test_restart_angle();
        @(negedge clk) FC_en = 1'b1;
        @(negedge clk) FC_en = 1'b0;
        chk_cnt++; if ({busy, row_en, bit_sel} !== {1'b1, 4'b0000, 4'd9}) $display("FAIL leave_finish got %h exp %h", {busy, row_en, bit_sel}, {1'b1, 4'b0000, 4'd9}); else pass_cnt++;
        pulse(22);
        chk_cnt++; if (led !== 4'd7 || color !== 2'd1) $display("FAIL pre_angle got %0d/%0d exp 7/1", led, color); else pass_cnt++;
        angle = 7'd5; SCLK = 1'b1;
        @(negedge clk);
        chk_cnt++; if ({color, led, bit_sel, busy, row_en} !== {2'd0, 4'd0, 4'd9, 1'b1, 4'b0000}) $display("FAIL angle_restart got %h exp %h", {color, led, bit_sel, busy, row_en}, {2'd0, 4'd0, 4'd9, 1'b1, 4'b0000}); else pass_cnt++;
        SCLK = 1'b0;
        pulse(1);
        chk_cnt++; if (color !== 2'd1 || led !== 4'd0) $display("FAIL post_angle got %0d/%0d exp 1/0", color, led); else pass_cnt++;
    endtask

    task automatic test_restart_fc();
        pulse(21);
        chk_cnt++; if (led !== 4'd7 || color !== 2'd1) $display("FAIL pre_fc got %0d/%0d exp 7/1", led, color); else pass_cnt++;
        FC_en = 1'b1; SCLK = 1'b1;
        repeat (4) @(negedge clk) SCLK = ~SCLK;
        @(negedge clk);
        FC_en = 1'b0; SCLK = 1'b0;
        chk_cnt++; if ({color, led, bit_sel, busy} !== {2'd0, 4'd0, 4'd9, 1'b1}) $display("FAIL fc_restart got %h exp %h", {color, led, bit_sel, busy}, {2'd0, 4'd0, 4'd9, 1'b1}); else pass_cnt++;
        pulse(1);
        chk_cnt++; if (color !== 2'd1 || led !== 4'd0) $display("FAIL post_fc got %0d/%0d exp 1/0", color, led); else pass_cnt++;
    endtask

    task automatic test_alt_config();
        pulse2(1535);
        chk_cnt++; if ({row_en2, busy2, lat2, latgs2, bit_sel2} !== {2'b10, 3'b111, 3'd0}) $display("FAIL alt_edge1535 got %b exp %b", {row_en2, busy2, lat2, latgs2, bit_sel2}, {2'b10, 3'b111, 3'd0}); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1 || bit_sel !== 4'd9) $display("FAIL alt_isolation got %b/%0d exp 1/9", busy, bit_sel); else pass_cnt++;
        pulse2(1);
        chk_cnt++; if ({row_en2, busy2, lat2, frame_done2} !== 5'b00_001) $display("FAIL alt_finish got %b exp 00001", {row_en2, busy2, lat2, frame_done2}); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        @(negedge clk) FC_en = 1'b1;
        @(negedge clk) FC_en = 1'b0;
        pulse(1487);
        chk_cnt++; if (row_en !== 4'b0100 || LAT !== 1'b1) $display("FAIL pre_reset got %b lat %b exp 0100 lat 1", row_en, LAT); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if ({row_en, LAT, LATGS, busy, frame_done} !== 8'b0000_0010) $display("FAIL async_reset_out got %b exp 00000010", {row_en, LAT, LATGS, busy, frame_done}); else pass_cnt++;
        chk_cnt++; if ({color, led, bit_sel} !== {2'd0, 4'd0, 4'd9}) $display("FAIL async_reset_cnt got %h exp %h", {color, led, bit_sel}, {2'd0, 4'd0, 4'd9}); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0; fd_cnt = 0;
        test_reset();
        test_alt_config();
        test_first_plane();
        test_row_phase();
        test_frame();
        test_restart_angle();
        test_restart_fc();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
